// File: rtl/sync_ram_bwe_pkg.sv
// sync_ram_pkg: shared state encoding, read-ordering constants and lane-count helper
package sync_ram_pkg;
    typedef enum logic {CLEAR, READY} state_t;
    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;
    function automatic int nbytes(input int word_size, input int byte_w);
        return word_size / byte_w;
    endfunction
endpackage

// File: rtl/sync_ram_bwe_if.sv
// sync_ram_bwe_if: request/response bundle between a RAM client and the RAM
interface sync_ram_bwe_if #(
    parameter int ADDR_SIZE = 10,
    parameter int WORD_SIZE = 32,
    parameter int BYTE_W    = 8
);
    logic                           cs;
    logic                           wr;
    logic [ADDR_SIZE-1:0]           addr;
    logic [WORD_SIZE-1:0]           data_in;
    logic [WORD_SIZE/BYTE_W-1:0]    be;
    logic                           init_req;
    logic [WORD_SIZE-1:0]           data_out;
    logic                           rd_valid;
    logic                           addr_err;
    logic                           busy;
    modport master (
        output cs, wr, addr, data_in, be, init_req,
        input  data_out, rd_valid, addr_err, busy
    );
    modport slave (
        input  cs, wr, addr, data_in, be, init_req,
        output data_out, rd_valid, addr_err, busy
    );
endinterface

// File: rtl/sync_ram_bwe_lane.sv
// ram_byte_lane: one byte-wide storage lane with its own write enable and registered read
module ram_byte_lane #(
    parameter int ADDR_SIZE = 10,
    parameter int BYTE_W    = 8,
    parameter int MEM_SIZE  = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_i,
    input  logic [ADDR_SIZE-1:0] waddr_i,
    input  logic [BYTE_W-1:0]    wdata_i,
    input  logic                 re_i,
    input  logic [ADDR_SIZE-1:0] raddr_i,
    output logic [BYTE_W-1:0]    rdata_o
);
    logic [BYTE_W-1:0] mem_q [MEM_SIZE];
    logic [BYTE_W-1:0] rdata_q;
    // Array write; no reset here, the clear engine zeroes the contents
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end
    // Read register captures the pre-write contents of the same edge and holds between reads
    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/sync_ram_bwe.sv
// sync_ram_bwe: byte-enable synchronous RAM with clear engine, range check and read pipeline
module sync_ram_bwe
    import sync_ram_pkg::*;
#(
    parameter int ADDR_SIZE = 10,
    parameter int WORD_SIZE = 32,
    parameter int BYTE_W    = 8,
    parameter int MEM_SIZE  = 1024,
    parameter int RD_MODE   = 0,
    parameter int OUT_REG   = 0
) (
    input  logic           clk,
    input  logic           rst,
    sync_ram_bwe_if.slave  bus
);
    localparam int NBYTES = nbytes(WORD_SIZE, BYTE_W);
    localparam logic [ADDR_SIZE:0]   MEM_LIM = (ADDR_SIZE+1)'(MEM_SIZE);
    localparam logic [ADDR_SIZE-1:0] LAST    = ADDR_SIZE'(MEM_SIZE - 1);
    state_t               state_q;
    logic [ADDR_SIZE-1:0] clr_cnt_q;
    logic                 clear;
    logic                 acc;
    logic                 in_rng;
    logic                 rd_req;
    logic [NBYTES-1:0]    we;
    logic [ADDR_SIZE-1:0] waddr;
    logic [WORD_SIZE-1:0] rdata;
    logic [WORD_SIZE-1:0] word1;
    logic [WORD_SIZE-1:0] din1_q;
    logic [NBYTES-1:0]    be1_q;
    logic                 v1_q;
    logic                 e1_q;
    logic                 oor1_q;
    // Access qualification and write steering between the clear sweep and client writes
    always_comb begin
        clear  = state_q == CLEAR;
        acc    = !clear && bus.cs;
        in_rng = {1'b0, bus.addr} < MEM_LIM;
        rd_req = acc && (!bus.wr || in_rng);
        waddr  = clear ? clr_cnt_q : bus.addr;
        we     = clear ? '1 : (acc && bus.wr && in_rng) ? bus.be : '0;
    end
    // Clear/ready controller; the sweep ends on the last valid word so the counter never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else if (clear) begin
            state_q   <= (clr_cnt_q == LAST) ? READY : CLEAR;
            clr_cnt_q <= (clr_cnt_q == LAST) ? '0 : clr_cnt_q + 1'b1;
        end else if (bus.init_req) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end
    end
    // First read stage: capture what is needed to form the returned word, only on reads
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            e1_q   <= 1'b0;
            oor1_q <= 1'b0;
            be1_q  <= '0;
            din1_q <= '0;
        end else begin
            v1_q <= rd_req;
            e1_q <= acc && !in_rng;
            if (rd_req) begin
                oor1_q <= !in_rng;
                be1_q  <= (bus.wr && RD_MODE == WR_FIRST) ? bus.be : '0;
                din1_q <= bus.data_in;
            end
        end
    end
    for (genvar i = 0; i < NBYTES; i++) begin : g_lane
        ram_byte_lane #(
            .ADDR_SIZE (ADDR_SIZE),
            .BYTE_W    (BYTE_W),
            .MEM_SIZE  (MEM_SIZE)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .we_i    (we[i]),
            .waddr_i (waddr),
            .wdata_i (clear ? '0 : bus.data_in[i*BYTE_W +: BYTE_W]),
            .re_i    (acc && in_rng),
            .raddr_i (bus.addr),
            .rdata_o (rdata[i*BYTE_W +: BYTE_W])
        );
        assign word1[i*BYTE_W +: BYTE_W] = oor1_q ? '0 :
                                           be1_q[i] ? din1_q[i*BYTE_W +: BYTE_W] :
                                           rdata[i*BYTE_W +: BYTE_W];
    end
    if (OUT_REG != 0) begin : g_oreg
        logic [WORD_SIZE-1:0] data_q;
        logic                 valid_q;
        logic                 err_q;
        // Optional output stage adds one cycle of read latency
        always_ff @(posedge clk) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                valid_q <= v1_q;
                err_q   <= e1_q;
                if (v1_q) data_q <= word1;
            end
        end
        assign bus.data_out = data_q;
        assign bus.rd_valid = valid_q;
        assign bus.addr_err = err_q;
    end else begin : g_direct
        assign bus.data_out = word1;
        assign bus.rd_valid = v1_q;
        assign bus.addr_err = e1_q;
    end
    assign bus.busy = clear;
endmodule
